// File: rtl/ldm_writeback_seq.sv
//==============================================================================
// Module      : ldm_writeback_seq
// Description : Load-multiple sequencer, the writer side of the register set.
//               A start pulse walks a 16-bit register list from index 0 up to
//               index 15 and issues one memory read per set bit at
//               consecutive word addresses (increment-after). Each returned
//               word goes to the register-set write port. A load that targets
//               register 15 goes to the PC-load strobe instead, because the
//               register set overwrites PC every cycle. When the list is
//               finished, the updated base can optionally be written back.
//
// Ports       :
//   clk            in   1    clock
//   rst            in   1    synchronous active-high reset
//   i_start        in   1    start pulse, sampled only in IDLE
//   i_reg_list     in   16   bit n set = load register n
//   i_base         in   DW   start address
//   i_base_idx     in   4    index of the base register
//   i_wback        in   1    write the updated base to i_base_idx
//   o_busy         out  1    operation in progress
//   o_done         out  1    one-cycle completion pulse
//   o_mem_rd_en    out  1    one-cycle memory read request
//   o_mem_addr     out  DW   read address, valid with o_mem_rd_en
//   i_mem_rdata    in   DW   read data
//   i_mem_rvalid   in   1    read data valid
//   o_addr_rd      out  4    register write address
//   o_rd           out  DW   register write data
//   o_rd_wr_en     out  1    register write enable
//   o_pc_load      out  1    one-cycle PC load strobe
//   o_pc_val       out  DW   PC load value
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ldm_writeback_seq #(
    parameter int DW   = 32,
    parameter int STEP = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [15:0]   i_reg_list,
    input  logic [DW-1:0] i_base,
    input  logic [3:0]    i_base_idx,
    input  logic          i_wback,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_mem_rd_en,
    output logic [DW-1:0] o_mem_addr,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_mem_rvalid,
    output logic [3:0]    o_addr_rd,
    output logic [DW-1:0] o_rd,
    output logic          o_rd_wr_en,
    output logic          o_pc_load,
    output logic [DW-1:0] o_pc_val
);

    // Register 15 is the program counter; writes to it use the PC-load path.
    localparam logic [3:0] c_PC_IDX = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state;
    logic [15:0]   r_pending;   // registers still to be loaded
    logic [15:0]   r_list;      // original list, for the base-in-list test
    logic [DW-1:0] r_addr;      // address of the current/next read
    logic [DW-1:0] r_base;      // original base, for the writeback value
    logic [3:0]    r_base_idx;
    logic          r_wback;
    logic [4:0]    r_count;     // number of registers in the list

    logic [3:0]    w_target;
    logic [15:0]   w_pending_clr;
    logic [DW-1:0] w_addr_next;
    logic [DW-1:0] w_wb_value;
    logic          w_base_in_list;
    logic [4:0]    w_list_count;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Lowest set bit of the pending mask. Scanning downward lets the last
    // (lowest) hit win. The mask does not change while a read is
    // outstanding, so this stays stable from REQ through the rvalid cycle.
    always_comb begin
        w_target = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_target = 4'(i);
            end
        end
    end

    assign w_pending_clr  = r_pending & ~(16'd1 << w_target);
    assign w_addr_next    = r_addr + DW'(STEP);
    assign w_wb_value     = r_base + (DW'(r_count) * DW'(STEP));
    assign w_base_in_list = r_list[r_base_idx];
    assign w_list_count   = popcount16(i_reg_list);

    // Every output is registered. A request is raised on the transition into
    // REQ, so the write for load k and the request for load k+1 appear
    // in the same cycle. o_busy drops one cycle after the o_done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pending   <= 16'd0;
            r_list      <= 16'd0;
            r_addr      <= '0;
            r_base      <= '0;
            r_base_idx  <= 4'd0;
            r_wback     <= 1'b0;
            r_count     <= 5'd0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_mem_rd_en <= 1'b0;
            o_mem_addr  <= '0;
            o_addr_rd   <= 4'd0;
            o_rd        <= '0;
            o_rd_wr_en  <= 1'b0;
            o_pc_load   <= 1'b0;
            o_pc_val    <= '0;
        end else begin
            // Strobes default low; address/data outputs hold their value.
            o_mem_rd_en <= 1'b0;
            o_rd_wr_en  <= 1'b0;
            o_pc_load   <= 1'b0;
            o_done      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    o_busy <= 1'b0;
                    if (i_start) begin
                        r_pending  <= i_reg_list;
                        r_list     <= i_reg_list;
                        r_addr     <= i_base;
                        r_base     <= i_base;
                        r_base_idx <= i_base_idx;
                        r_wback    <= i_wback;
                        r_count    <= w_list_count;
                        o_busy     <= 1'b1;
                        if (i_reg_list != 16'd0) begin
                            r_state     <= S_REQ;
                            o_mem_rd_en <= 1'b1;
                            o_mem_addr  <= i_base;
                        end else begin
                            // Empty list: no reads, no writes, no writeback.
                            r_state <= S_DONE;
                        end
                    end
                end

                S_REQ: begin
                    o_busy  <= 1'b1;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    o_busy <= 1'b1;
                    if (i_mem_rvalid) begin
                        if (w_target == c_PC_IDX) begin
                            o_pc_load <= 1'b1;
                            o_pc_val  <= i_mem_rdata;
                        end else begin
                            o_rd_wr_en <= 1'b1;
                            o_addr_rd  <= w_target;
                            o_rd       <= i_mem_rdata;
                        end
                        r_pending <= w_pending_clr;
                        r_addr    <= w_addr_next;
                        if (w_pending_clr != 16'd0) begin
                            r_state     <= S_REQ;
                            o_mem_rd_en <= 1'b1;
                            o_mem_addr  <= w_addr_next;
                        end else if (r_wback && !w_base_in_list) begin
                            r_state <= S_WB;
                        end else begin
                            // A base register that is also loaded keeps the
                            // loaded value, so writeback is skipped.
                            r_state <= S_DONE;
                        end
                    end
                end

                S_WB: begin
                    o_busy <= 1'b1;
                    if (r_base_idx == c_PC_IDX) begin
                        o_pc_load <= 1'b1;
                        o_pc_val  <= w_wb_value;
                    end else begin
                        o_rd_wr_en <= 1'b1;
                        o_addr_rd  <= r_base_idx;
                        o_rd       <= w_wb_value;
                    end
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    o_busy  <= 1'b1;
                    o_done  <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/ldm_writeback_seq.md
Name: ldm_writeback_seq

Overview:
- Load-multiple sequencer: the writer side of the register set.
- On a start pulse it walks a 16-bit register list in ascending index order and issues one memory read per set bit at consecutive word addresses.
- Each returned word is driven onto the register-set write port (rd address, rd data, write enable).
- Optional base-register writeback at the end; PC-destined loads go to the PC-load path, because the register set overwrites PC every cycle.

Parameters:
DW, 32, data and address width in bits
STEP, 4, byte increment between consecutive load addresses

Ports:
clk  in  1  clock
rst  in  1  reset
i_start  in  1  start pulse; sampled only in IDLE
i_reg_list  in  16  bit n set = load register n
i_base  in  DW  start address (increment-after)
i_base_idx  in  4  index of base register
i_wback  in  1  write updated base to i_base_idx
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse when the operation completes
o_mem_rd_en  out  1  one-cycle read request
o_mem_addr  out  DW  read address, valid with o_mem_rd_en
i_mem_rdata  in  DW  read data
i_mem_rvalid  in  1  read data valid
o_addr_rd  out  4  register write address
o_rd  out  DW  register write data
o_rd_wr_en  out  1  register write enable
o_pc_load  out  1  one-cycle PC load strobe
o_pc_val  out  DW  PC load value

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock. All outputs registered. Reset values:
  - o_busy=0, o_done=0, o_mem_rd_en=0, o_rd_wr_en=0, o_pc_load=0.
  - o_mem_addr=0, o_addr_rd=0, o_rd=0, o_pc_val=0.
  - state=IDLE, pending mask=0.
- Reset mid-operation: abort immediately. The outstanding read is dropped, and a late i_mem_rvalid is ignored in IDLE.
- States: IDLE, REQ, WAIT, WB, DONE.
- IDLE:
  - On i_start, latch pending=i_reg_list, addr=i_base, base_idx, wback. Set count=popcount(list).
  - Go to REQ if the list is nonzero.
  - Empty list goes to DONE: no reads, no writes.
  - i_start in any other state is ignored.
- REQ:
  - o_mem_rd_en=1 for exactly one cycle; o_mem_addr=addr.
  - Target = lowest set bit of pending. Go to WAIT.
- WAIT:
  - Hold until i_mem_rvalid; unbounded wait, no timeout.
  - Only one read is outstanding at a time.
- On the i_mem_rvalid cycle:
  - Target != 15: next cycle o_rd_wr_en=1, o_addr_rd=target, o_rd=i_mem_rdata.
  - Target == 15: next cycle o_pc_load=1, o_pc_val=i_mem_rdata, o_rd_wr_en=0.
  - Clear target bit in pending; addr += STEP (mod 2^DW, wraps silently).
  - Next state: REQ if pending != 0; else WB if wback and base_idx not in original list; else DONE.
  - So the write of load k and the request of load k+1 occur in the same cycle.
- WB:
  - o_rd_wr_en=1, o_addr_rd=base_idx, o_rd=i_base + STEP*count (DW-bit truncated). Go to DONE.
  - If base_idx is in the list, the loaded value wins and WB is skipped.
  - If base_idx=15 and wback, the result goes on o_pc_load/o_pc_val instead.
- DONE: o_done=1 for one cycle; o_busy=0 from the next cycle; return to IDLE.
- Strobes: o_rd_wr_en, o_pc_load, o_mem_rd_en and o_done are single-cycle; never asserted in IDLE.
- o_addr_rd/o_rd hold their last value when o_rd_wr_en=0.
- Minimum latency: an N-register load with zero-wait memory (rvalid the cycle after rd_en) takes 2N+2 cycles from start to o_done (+1 with WB).

Test Plan:
- List=0x0006, base=0x100, wback=0, memory returns 0xA,0xB one cycle after each request:
  - Reads at 0x100, 0x104.
  - r1=0xA, then r2=0xB.
  - o_done at cycle 6 after start; no further writes.
- List=0x0011, base=0x200, base_idx=13, wback=1:
  - Writes r0, r4, then r13=0x208.
  - o_done follows the WB cycle.
- List=0x0009, base_idx=3, wback=1:
  - r3 gets the loaded word; no writeback of 0x...+8.
- List=0x8001, base=0xFFFFFFFC:
  - Addresses 0xFFFFFFFC, then 0x00000000 (wrap).
  - r0 written via o_rd_wr_en; PC loaded via o_pc_load with the second word; o_rd_wr_en low that cycle.
- List=0x0000, i_start:
  - No o_mem_rd_en, no writes; o_done pulses 2 cycles after start.
- List=0x00FF with 3-cycle memory latency:
  - Assert rst during the 4th WAIT; the next cycle all outputs are 0 and state is IDLE.
  - A stray i_mem_rvalid causes no write.
  - A new i_start issued while busy before the reset is ignored.
